// File: rtl/register_file_ba.sv
// Parametrised register file: one write port, two combinational read ports with BA zeroing on A,
// optional hard-wired R0 and write bypass, plus a per-register busy scoreboard for hazard detection.
module register_file_ba #(
    parameter int               WIDTH        = 32,
    parameter int               NUM_REGS     = 16,
    parameter int               ADDR_W       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               R0_HARDWIRED = 1'b0,
    parameter bit               BYPASS       = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic                ba_a,
    output logic [WIDTH-1:0]    rdata_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [WIDTH-1:0]    rdata_b,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_ok;
    logic                iss_ok;
    logic                zero_a;
    logic                zero_b;
    logic                fwd_a;
    logic                fwd_b;

    // Writes and issues aimed at a hard-wired R0 are discarded before they touch any state.
    assign wr_ok  = we     && !(R0_HARDWIRED && (waddr    == '0));
    assign iss_ok = iss_en && !(R0_HARDWIRED && (iss_addr == '0));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (R0_HARDWIRED && (i == 0)) ? '0 : RESET_VAL;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Set is applied after clear so a same-cycle issue to the written register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign zero_a = (raddr_a == '0) && (ba_a || R0_HARDWIRED);
    assign zero_b = (raddr_b == '0) && R0_HARDWIRED;
    assign fwd_a  = BYPASS && wr_ok && (waddr == raddr_a);
    assign fwd_b  = BYPASS && wr_ok && (waddr == raddr_b);

    assign rdata_a  = zero_a ? '0 : (fwd_a ? wdata : regs[raddr_a]);
    assign rdata_b  = zero_b ? '0 : (fwd_b ? wdata : regs[raddr_b]);
    assign busy_a   = !zero_a && busy[raddr_a];
    assign busy_b   = !zero_b && busy[raddr_b];
    assign busy_vec = busy;

endmodule

// File: tb/tb_register_file_ba.sv
// Bench for register_file_ba: three configurations (bypass, no bypass, hard-wired R0) share stimulus
// and are compared against an array-based model of the register file and scoreboard.
module tb_register_file_ba;

    localparam logic [31:0] RV = 32'h5;

    logic        clk = 1'b0;
    logic        clr;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr_a;
    logic        ba_a;
    logic [3:0]  raddr_b;
    logic        iss_en;
    logic [3:0]  iss_addr;

    logic [31:0] rd_a [3];
    logic [31:0] rd_b [3];
    logic        bz_a [3];
    logic        bz_b [3];
    logic [15:0] bvec [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [3][16];
    logic [15:0] m_busy [3];

    always #5 clk = ~clk;

    // c=0: bypass; c=1: no bypass; c=2: hard-wired R0 with bypass
    register_file_ba #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .RESET_VAL(RV),
                       .R0_HARDWIRED(1'b0), .BYPASS(1'b1)) u_byp (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .ba_a(ba_a), .rdata_a(rd_a[0]),
        .raddr_b(raddr_b), .rdata_b(rd_b[0]),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(bz_a[0]), .busy_b(bz_b[0]), .busy_vec(bvec[0]));

    register_file_ba #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .RESET_VAL(RV),
                       .R0_HARDWIRED(1'b0), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .ba_a(ba_a), .rdata_a(rd_a[1]),
        .raddr_b(raddr_b), .rdata_b(rd_b[1]),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(bz_a[1]), .busy_b(bz_b[1]), .busy_vec(bvec[1]));

    register_file_ba #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .RESET_VAL(RV),
                       .R0_HARDWIRED(1'b1), .BYPASS(1'b1)) u_hw (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .ba_a(ba_a), .rdata_a(rd_a[2]),
        .raddr_b(raddr_b), .rdata_b(rd_b[2]),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(bz_a[2]), .busy_b(bz_b[2]), .busy_vec(bvec[2]));

    function automatic bit cfg_byp(int c);
        return c != 1;
    endfunction

    function automatic bit cfg_hw(int c);
        return c == 2;
    endfunction

    function automatic logic [31:0] exp_rdata(int c, logic [3:0] a, bit use_ba);
        if (a == 4'd0 && (use_ba || cfg_hw(c))) return 32'h0;
        if (cfg_byp(c) && we && waddr == a && !(cfg_hw(c) && a == 4'd0)) return wdata;
        return m_regs[c][a];
    endfunction

    function automatic bit exp_busy(int c, logic [3:0] a, bit use_ba);
        if (a == 4'd0 && (use_ba || cfg_hw(c))) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 16; i++) m_regs[c][i] = (i == 0 && cfg_hw(c)) ? 32'h0 : RV;
            m_busy[c] = 16'h0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (we && !(cfg_hw(c) && waddr == 4'd0)) begin
                m_regs[c][waddr] = wdata;
                m_busy[c][waddr] = 1'b0;
            end
            if (iss_en && !(cfg_hw(c) && iss_addr == 4'd0)) m_busy[c][iss_addr] = 1'b1;
        end
    endtask

    // Advance one clock; model follows the edge using the inputs held across it.
    task automatic step();
        @(posedge clk);
        if (clr) model_edge();
        #1;
    endtask

    task automatic test_reset();
        #7 clr = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bvec[c] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_busy_vec[%0d]: got %h want 0000", c, bvec[c]);
            end
        end
        for (int a = 1; a < 16; a++) begin
            raddr_a = 4'(a);
            raddr_b = 4'(15 - a);
            #1;
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (rd_a[c] !== RV) begin
                    n_fail++;
                    $display("FAIL reset_rdata_a[%0d] addr %0d: got %h want %h", c, a, rd_a[c], RV);
                end
            end
        end
        n_checks++;
        if (rd_b[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hw_r0: got %h want 0", rd_b[2]);
        end
        step();
        clr = 1'b1;
        step();
        step();
        for (int a = 0; a < 16; a++) begin
            raddr_b = 4'(a);
            #1;
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (rd_b[c] !== ((c == 2 && a == 0) ? 32'h0 : RV)) begin
                    n_fail++;
                    $display("FAIL reset_hold[%0d] addr %0d: got %h", c, a, rd_b[c]);
                end
            end
        end
    endtask

    task automatic test_write_bypass();
        step();
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; raddr_a = 4'd3; ba_a = 1'b0;
        #3;
        n_checks++;
        if (rd_a[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_pre: got %h want deadbeef", rd_a[0]);
        end
        n_checks++;
        if (rd_a[1] !== RV) begin
            n_fail++; $display("FAIL nobypass_pre: got %h want %h", rd_a[1], RV);
        end
        step();
        we = 1'b0;
        #3;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rd_a[c] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL write_post[%0d]: got %h want deadbeef", c, rd_a[c]);
            end
        end
    endtask

    task automatic test_ba_zero();
        step();
        we = 1'b1; waddr = 4'd0; wdata = 32'h1234;
        step();
        we = 1'b0; raddr_a = 4'd0; raddr_b = 4'd0; ba_a = 1'b1;
        #3;
        n_checks++;
        if (rd_a[0] !== 32'h0 || rd_b[0] !== 32'h1234 || bz_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ba_zero: a=%h b=%h busy_a=%b want 0/1234/0", rd_a[0], rd_b[0], bz_a[0]);
        end
        n_checks++;
        if (rd_a[2] !== 32'h0 || rd_b[2] !== 32'h0) begin
            n_fail++; $display("FAIL ba_hw: a=%h b=%h want 0/0", rd_a[2], rd_b[2]);
        end
        ba_a = 1'b0;
        #1;
        n_checks++;
        if (rd_a[1] !== 32'h1234 || rd_a[2] !== 32'h0) begin
            n_fail++; $display("FAIL ba_off: nobyp=%h hw=%h want 1234/0", rd_a[1], rd_a[2]);
        end
    endtask

    task automatic test_scoreboard();
        step();
        iss_en = 1'b1; iss_addr = 4'd5;
        step();
        iss_en = 1'b0; raddr_b = 4'd5;
        #3;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bvec[c][5] !== 1'b1 || bz_b[c] !== 1'b1) begin
                n_fail++; $display("FAIL issue[%0d]: vec=%h busy_b=%b want bit5=1", c, bvec[c], bz_b[c]);
            end
        end
        iss_en = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 32'hA5A5A5A5;
        step();
        iss_en = 1'b0; we = 1'b0;
        #3;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bvec[c][5] !== 1'b1 || rd_b[c] !== 32'hA5A5A5A5) begin
                n_fail++; $display("FAIL set_wins[%0d]: vec=%h data=%h", c, bvec[c], rd_b[c]);
            end
        end
        we = 1'b1;
        step();
        we = 1'b0;
        #3;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bvec[c] !== 16'h0 || bz_b[c] !== 1'b0) begin
                n_fail++; $display("FAIL clear[%0d]: vec=%h want 0000", c, bvec[c]);
            end
        end
        iss_en = 1'b1; iss_addr = 4'd0;
        step();
        iss_en = 1'b0; raddr_a = 4'd0; ba_a = 1'b1;
        #3;
        n_checks++;
        if (bvec[0] !== 16'h0001 || bvec[2] !== 16'h0 || bz_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_r0: byp=%h hw=%h busy_a=%b want 0001/0000/0", bvec[0], bvec[2], bz_a[0]);
        end
        ba_a = 1'b0;
        #1;
        n_checks++;
        if (bz_a[0] !== 1'b1 || bz_a[2] !== 1'b0) begin
            n_fail++; $display("FAIL busy_a_r0: byp=%b hw=%b want 1/0", bz_a[0], bz_a[2]);
        end
    endtask

    task automatic test_async_mid();
        step();
        iss_en = 1'b1; iss_addr = 4'd1;
        step();
        iss_addr = 4'd2;
        step();
        iss_en = 1'b0; we = 1'b1; waddr = 4'd7; wdata = 32'h77; raddr_a = 4'd3; ba_a = 1'b0;
        #2 clr = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bvec[c] !== 16'h0 || rd_a[c] !== RV) begin
                n_fail++; $display("FAIL async_mid[%0d]: vec=%h data=%h want 0000/%h", c, bvec[c], rd_a[c], RV);
            end
        end
        #1 clr = 1'b1;
        waddr = 4'd9; wdata = 32'h99;
        step();
        we = 1'b0; raddr_b = 4'd9;
        #3;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rd_b[c] !== 32'h99) begin
                n_fail++; $display("FAIL first_write[%0d]: got %h want 00000099", c, rd_b[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            step();
            if ($urandom_range(0, 59) == 0) begin
                clr = 1'b0;
                model_reset();
            end else begin
                clr = 1'b1;
            end
            we       = 1'($urandom_range(0, 1));
            waddr    = 4'($urandom_range(0, 7));
            wdata    = $urandom;
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 4'($urandom_range(0, 7));
            raddr_a  = 4'($urandom_range(0, 7));
            raddr_b  = 4'($urandom_range(0, 7));
            ba_a     = 1'($urandom_range(0, 1));
            #3;
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (rd_a[c] !== exp_rdata(c, raddr_a, ba_a) || rd_b[c] !== exp_rdata(c, raddr_b, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d] it %0d: a=%h/%h b=%h/%h", c, it,
                             rd_a[c], exp_rdata(c, raddr_a, ba_a), rd_b[c], exp_rdata(c, raddr_b, 1'b0));
                end
                n_checks++;
                if (bvec[c] !== m_busy[c] || bz_a[c] !== exp_busy(c, raddr_a, ba_a)
                    || bz_b[c] !== exp_busy(c, raddr_b, 1'b0)) begin
                    n_fail++;
                    $display("FAIL rand_busy[%0d] it %0d: vec=%h want %h a=%b b=%b", c, it,
                             bvec[c], m_busy[c], bz_a[c], bz_b[c]);
                end
            end
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; ba_a = 1'b0;
        raddr_b = '0; iss_en = 1'b0; iss_addr = '0;
        model_reset();
        test_reset();
        test_write_bypass();
        test_ba_zero();
        test_scoreboard();
        test_async_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_ba.md
Name: register_file_ba

Overview:
- Parametrised successor to the single R0 register: a NUM_REGS x WIDTH general-purpose register file for the datapath.
- One write port and two combinational read ports (A, B).
- Base-address (BA) zeroing of R0 on port A; R0 may optionally be hard-wired to zero.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so the control unit can detect read-after-write hazards on in-flight results.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 16, number of registers; power of two, >= 2.
- ADDR_W, 4, address width; must equal log2(NUM_REGS).
- RESET_VAL, 0, value loaded into every register (except a hard-wired R0) on reset.
- R0_HARDWIRED, 0, 1 = R0 always reads 0, and writes/issues to R0 are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  ADDR_W  read address, port A.
- ba_a  in  1  BA mode for port A: when raddr_a==0, rdata_a reads 0.
- rdata_a  out  WIDTH  read data, port A.
- raddr_b  in  ADDR_W  read address, port B.
- rdata_b  out  WIDTH  read data, port B.
- iss_en  in  1  issue: mark register iss_addr busy.
- iss_addr  in  ADDR_W  register being issued as a destination.
- busy_a  out  1  busy bit of raddr_a.
- busy_b  out  1  busy bit of raddr_b.
- busy_vec  out  NUM_REGS  all busy bits; bit i = register i.

Behaviour:
- Reset (clr low, asynchronous, regardless of clk):
  - All registers take RESET_VAL; R0 takes 0 if R0_HARDWIRED.
  - All busy bits clear.
  - rdata_a/rdata_b reflect the reset contents combinationally; busy_a, busy_b and busy_vec read 0.
- Release: clr deasserting takes effect on the next rising edge; no write or issue is lost or half-applied at the release edge.
- Write: on a rising edge with we=1, reg[waddr] <= wdata.
  - R0_HARDWIRED=1 and waddr==0: the write is dropped.
  - ba_a has no effect on writes.
- Read: purely combinational, zero latency.
  - rdata_a = 0 if (raddr_a==0 and (ba_a or R0_HARDWIRED)).
  - Otherwise, if BYPASS and we and waddr==raddr_a and the write is not dropped: rdata_a = wdata.
  - Otherwise rdata_a = reg[raddr_a].
  - Port B: same rules without ba_a (R0_HARDWIRED still applies).
  - BYPASS=0: reads return pre-edge contents; the new value is visible the cycle after the write.
- Scoreboard, evaluated per rising edge:
  - iss_en=1: busy[iss_addr] <= 1.
  - we=1: busy[waddr] <= 0.
  - iss_en and we on the same address in the same cycle: set wins (a new producer was issued).
  - Different addresses: both actions apply.
  - Issue to R0 with R0_HARDWIRED=1 is ignored; busy[0] stays 0.
  - A write to a non-busy register is legal and leaves busy at 0.
  - Re-issuing a busy register keeps it busy.
- busy_a/busy_b: busy[raddr] from the current state, combinational, not bypassed.
  - busy_a is 0 whenever port A reads 0 via the BA/hard-wired rule.
  - busy_b is 0 when raddr_b==0 and R0_HARDWIRED.
- No X propagation: all addresses are in range by construction (power-of-two depth).

Test Plan:
- Reset value: RESET_VAL=32'h5, drive clr low mid-cycle -> all rdata read 32'h5 immediately; busy_vec=0; release, no writes -> contents hold.
- Write/read, BYPASS=1: we=1, waddr=3, wdata=32'hDEADBEEF, raddr_a=3 in the same cycle -> rdata_a=32'hDEADBEEF before the edge; next cycle with we=0 -> still 32'hDEADBEEF.
- BYPASS=0: same stimulus -> rdata_a shows the old value (RESET_VAL) pre-edge and 32'hDEADBEEF the following cycle.
- BA zeroing: write R0=32'h1234; raddr_a=raddr_b=0, ba_a=1 -> rdata_a=0, rdata_b=32'h1234, busy_a=0.
- BA zeroing, hard-wired: repeat the previous case with R0_HARDWIRED=1 -> both ports read 0; the write is dropped.
- Scoreboard: iss_en, iss_addr=5 -> busy_vec[5]=1 next cycle, busy_b=1 with raddr_b=5. Then iss_en with iss_addr=5 and we with waddr=5 in the same cycle -> busy stays 1. Then we alone to 5 -> busy clears.
- Async reset mid-operation: with busy bits set and pending writes, pulse clr low between edges -> busy_vec=0 and registers=RESET_VAL without a clock edge; the first write after release lands correctly.
